// File: rtl/max7219_rx.sv
// max7219_rx -- receive-side model of the MAX7219 serial interface.
//
// Samples SCLK/DIN/CS in the clk domain, assembles 16-bit frames and decodes
// them into the MAX7219 register file. Serves as a loopback checker for the
// MAX7219 driver and as a display-state monitor.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth on SCLK, DIN and CS (>= 2)
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   SCLK, DIN, CS serial interface pins (asynchronous to clk, CS active low)
//   row_sel       frame-buffer row to read (0 = digit register 1)
//   row_data      effective row pixels, registered
//   wr_valid      one-cycle pulse per accepted 16-bit frame
//   wr_addr       address nibble of the last accepted frame
//   wr_data       data byte of the last accepted frame
//   frame_err     one-cycle pulse for a frame of 1..15 bits
//   shutdown, decode_mode, intensity, scan_limit, display_test
//                 decoded control registers
//
// Configuration macro: MAX7219_RX_FRAMEBUF_EN
//   defined   -> 8x8 frame buffer and effective-row logic present
//   undefined -> row_data is constant 0x00, row_sel unused
module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       DIN,
  input  logic       CS,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       shutdown,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       display_test
);

  // Synchronizers. CS resets to its idle (high) level so that a CS held low
  // across reset release is seen as a fresh frame start.
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] din_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic                   sclk_d_reg;
  logic                   cs_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      din_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      sclk_d_reg    <= 1'b0;
      cs_d_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
      din_sync_reg  <= {din_sync_reg[SYNC_STAGES-2:0], DIN};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
      cs_d_reg      <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  logic sclk_s, din_s, cs_s;
  logic sclk_rise, cs_rise, cs_fall, bit_capture;
  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign din_s     = din_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;
  assign cs_fall   = ~cs_s & cs_d_reg;
  // Synchronized CS is high during a CS-rise cycle, so an SCLK rise seen in
  // the same cycle is dropped here without extra logic.
  assign bit_capture = sclk_rise & ~cs_s;

  logic [15:0] sr_reg;
  logic [4:0]  bit_cnt_reg;
  logic [4:0]  cnt_base;
  logic        frame_ok;
  logic        frame_short;

  // A CS fall coinciding with an SCLK rise clears first, then counts the bit.
  assign cnt_base    = cs_fall ? 5'd0 : bit_cnt_reg;
  assign frame_ok    = cs_rise && (bit_cnt_reg == 5'd16);
  assign frame_short = cs_rise && (bit_cnt_reg != 5'd0) && (bit_cnt_reg < 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg       <= '0;
      bit_cnt_reg  <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_err    <= 1'b0;
      shutdown     <= 1'b1;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      display_test <= 1'b0;
    end else begin
      wr_valid  <= frame_ok;
      frame_err <= frame_short;

      if (bit_capture) begin
        sr_reg      <= {sr_reg[14:0], din_s};
        bit_cnt_reg <= (cnt_base == 5'd16) ? 5'd16 : cnt_base + 5'd1;
      end else if (cs_fall) begin
        bit_cnt_reg <= 5'd0;
      end

      if (frame_ok) begin
        wr_addr <= sr_reg[11:8];
        wr_data <= sr_reg[7:0];
        case (sr_reg[11:8])
          4'h9:    decode_mode  <= sr_reg[7:0];
          4'hA:    intensity    <= sr_reg[3:0];
          4'hB:    scan_limit   <= sr_reg[2:0];
          4'hC:    shutdown     <= ~sr_reg[0];
          4'hF:    display_test <= sr_reg[0];
          default: ;
        endcase
      end
    end
  end

  // The top bit only ever leaves the shift register; the frame ignores it.
  logic unused_sr_msb;
  assign unused_sr_msb = sr_reg[15];

`ifdef MAX7219_RX_FRAMEBUF_EN
  logic [7:0] fb_reg [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) fb_reg[i] <= '0;
      row_data <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (frame_ok && (sr_reg[11:8] == 4'(i + 1))) fb_reg[i] <= sr_reg[7:0];
      end
      // Display test overrides everything, then blanking, then pixels.
      if (display_test)                        row_data <= 8'hFF;
      else if (shutdown || row_sel > scan_limit) row_data <= 8'h00;
      else                                     row_data <= fb_reg[row_sel];
    end
  end
`else
  logic unused_row_sel;
  assign unused_row_sel = ^row_sel;
  assign row_data       = 8'h00;
`endif

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SCLK, DIN, CS;
  logic [2:0] row_sel;
  logic [7:0] row_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       shutdown;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       display_test;

  always #5 clk = ~clk;

  max7219_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .DIN(DIN), .CS(CS),
    .row_sel(row_sel), .row_data(row_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .shutdown(shutdown), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .display_test(display_test)
  );

`ifdef MAX7219_RX_FRAMEBUF_EN
  localparam bit FB_ON = 1'b1;
`else
  localparam bit FB_ON = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (register-file view) ----------------
  logic       m_sd, m_dt, m_ev, m_ee;
  logic [7:0] m_dec, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_sl;
  logic [7:0] m_rows [8];

  function automatic void model_reset();
    m_sd = 1'b1; m_dt = 1'b0; m_dec = '0; m_int = '0; m_sl = '0;
    m_addr = '0; m_data = '0;
    for (int i = 0; i < 8; i++) m_rows[i] = '0;
  endfunction

  // The frame keeps the last 16 bits shifted in, i.e. bits[15:0] of the word.
  function automatic void model_apply(input logic [31:0] bits, input int n);
    int a;
    m_ev = 1'b0; m_ee = 1'b0;
    if (n >= 16) begin
      m_ev = 1'b1; m_addr = bits[11:8]; m_data = bits[7:0];
      a = int'(m_addr);
      if (a >= 1 && a <= 8) m_rows[a-1] = m_data;
      else if (a == 9)  m_dec = m_data;
      else if (a == 10) m_int = m_data[3:0];
      else if (a == 11) m_sl  = m_data[2:0];
      else if (a == 12) m_sd  = ~m_data[0];
      else if (a == 15) m_dt  = m_data[0];
    end else if (n > 0) begin
      m_ee = 1'b1;
    end
  endfunction

  function automatic logic [7:0] model_row(input logic [2:0] rs);
    if (!FB_ON) return 8'h00;
    if (m_dt) return 8'hFF;
    if (m_sd || int'(rs) > int'(m_sl)) return 8'h00;
    return m_rows[rs];
  endfunction

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DIN = bits[i];
      tick(2);
      SCLK = 1'b1;
      tick(3);
      SCLK = 1'b0;
      tick(1);
    end
  endtask

  // Watch the 8 cycles after a CS rise; record pulses and the cycle they hit.
  task automatic watch(output int vc, output int ec, output int pc);
    vc = 0; ec = 0; pc = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (wr_valid)  begin vc++; pc = k; end
      if (frame_err) begin ec++; pc = k; end
    end
  endtask

  task automatic run_frame(input logic [31:0] bits, input int n,
                           output int vc, output int ec, output int pc);
    CS = 1'b0;
    tick(3);
    shift_bits(bits, n);
    tick(2);
    CS = 1'b1;
    watch(vc, ec, pc);
    model_apply(bits, n);
    tick(2);
  endtask

  task automatic check_pulses(input string tag, input int vc, input int ec, input int pc,
                              input logic ev, input logic ee);
    check({tag, " wr_valid count"}, vc, {31'd0, ev});
    check({tag, " frame_err count"}, ec, {31'd0, ee});
    if (vc + ec > 0) check({tag, " pulse latency"}, pc, 3);
  endtask

  task automatic check_model_state(input string tag);
    check({tag, " shutdown"}, shutdown, m_sd);
    check({tag, " decode_mode"}, decode_mode, m_dec);
    check({tag, " intensity"}, intensity, m_int);
    check({tag, " scan_limit"}, scan_limit, m_sl);
    check({tag, " display_test"}, display_test, m_dt);
    check({tag, " wr_addr"}, wr_addr, m_addr);
    check({tag, " wr_data"}, wr_data, m_data);
  endtask

  task automatic sweep_rows(input string tag);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      tick(1);
      check($sformatf("%s row_data[%0d]", tag, r), row_data, model_row(3'(r)));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] frame; int nbits; logic [2:0] rs;
    logic ev; logic ee; logic [3:0] ea; logic [7:0] ed;
    logic sd; logic [7:0] dec; logic [3:0] inten; logic [2:0] sl; logic dt; logic [7:0] row;
  } tv_t;

  localparam int NTV = 17;
  tv_t tv [NTV];

  initial begin
    int vc, ec, pc;
    logic [31:0] rbits;
    int rn, sel;

    //        frame       n   rs  ev ee ea    ed     sd dec    int   sl  dt row
    tv[0]  = '{32'h0C01, 16, 0, 1, 0, 4'hC, 8'h01, 0, 8'h00, 4'h0, 0, 0, 8'h00};
    tv[1]  = '{32'h0900, 16, 0, 1, 0, 4'h9, 8'h00, 0, 8'h00, 4'h0, 0, 0, 8'h00};
    tv[2]  = '{32'h0B07, 16, 0, 1, 0, 4'hB, 8'h07, 0, 8'h00, 4'h0, 7, 0, 8'h00};
    tv[3]  = '{32'h0A0F, 16, 0, 1, 0, 4'hA, 8'h0F, 0, 8'h00, 4'hF, 7, 0, 8'h00};
    tv[4]  = '{32'h0F00, 16, 0, 1, 0, 4'hF, 8'h00, 0, 8'h00, 4'hF, 7, 0, 8'h00};
    tv[5]  = '{32'h013C, 16, 0, 1, 0, 4'h1, 8'h3C, 0, 8'h00, 4'hF, 7, 0, 8'h3C};
    tv[6]  = '{32'h0ABC, 12, 0, 0, 1, 4'h1, 8'h3C, 0, 8'h00, 4'hF, 7, 0, 8'h3C};
    tv[7]  = '{32'hAB0305, 24, 2, 1, 0, 4'h3, 8'h05, 0, 8'h00, 4'hF, 7, 0, 8'h05};
    tv[8]  = '{32'h0F01, 16, 5, 1, 0, 4'hF, 8'h01, 0, 8'h00, 4'hF, 7, 1, 8'hFF};
    tv[9]  = '{32'h0F00, 16, 5, 1, 0, 4'hF, 8'h00, 0, 8'h00, 4'hF, 7, 0, 8'h00};
    tv[10] = '{32'h0B02, 16, 5, 1, 0, 4'hB, 8'h02, 0, 8'h00, 4'hF, 2, 0, 8'h00};
    tv[11] = '{32'h0C00, 16, 0, 1, 0, 4'hC, 8'h00, 1, 8'h00, 4'hF, 2, 0, 8'h00};
    tv[12] = '{32'h0C01, 16, 0, 1, 0, 4'hC, 8'h01, 0, 8'h00, 4'hF, 2, 0, 8'h3C};
    tv[13] = '{32'h0D55, 16, 2, 1, 0, 4'hD, 8'h55, 0, 8'h00, 4'hF, 2, 0, 8'h05};
    tv[14] = '{32'h0000, 16, 1, 1, 0, 4'h0, 8'h00, 0, 8'h00, 4'hF, 2, 0, 8'h00};
    tv[15] = '{32'h0000,  0, 2, 0, 0, 4'h0, 8'h00, 0, 8'h00, 4'hF, 2, 0, 8'h05};
    tv[16] = '{32'h09A5, 16, 2, 1, 0, 4'h9, 8'hA5, 0, 8'hA5, 4'hF, 2, 0, 8'h05};

    rst_n = 1'b0; SCLK = 1'b0; DIN = 1'b0; CS = 1'b1; row_sel = 3'd0;
    model_reset();
    tick(3);
    check("reset shutdown", shutdown, 1);
    check("reset decode_mode", decode_mode, 0);
    check("reset intensity", intensity, 0);
    check("reset scan_limit", scan_limit, 0);
    check("reset display_test", display_test, 0);
    check("reset wr_valid", wr_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset row_data", row_data, 0);
    rst_n = 1'b1;
    tick(3);

    for (int t = 0; t < NTV; t++) begin
      row_sel = tv[t].rs;
      run_frame(tv[t].frame, tv[t].nbits, vc, ec, pc);
      check_pulses($sformatf("tv%0d", t), vc, ec, pc, tv[t].ev, tv[t].ee);
      if (tv[t].ev) begin
        check($sformatf("tv%0d wr_addr", t), wr_addr, tv[t].ea);
        check($sformatf("tv%0d wr_data", t), wr_data, tv[t].ed);
      end
      check($sformatf("tv%0d shutdown", t), shutdown, tv[t].sd);
      check($sformatf("tv%0d decode_mode", t), decode_mode, tv[t].dec);
      check($sformatf("tv%0d intensity", t), intensity, tv[t].inten);
      check($sformatf("tv%0d scan_limit", t), scan_limit, tv[t].sl);
      check($sformatf("tv%0d display_test", t), display_test, tv[t].dt);
      check($sformatf("tv%0d row_data", t), row_data, FB_ON ? tv[t].row : 8'h00);
      sweep_rows($sformatf("tv%0d", t));
      $display("tv%0d frame=%0h n=%0d wr_valid=%0d frame_err=%0d row_data=%0h",
               t, tv[t].frame, tv[t].nbits, vc, ec, row_data);
    end

    // CS fall and SCLK rise land in the same cycle: that bit must count.
    DIN = 1'b0;           // bit 15 of 0x0B05
    tick(2);
    CS = 1'b0; SCLK = 1'b1;
    tick(3);
    SCLK = 1'b0;
    tick(1);
    shift_bits(32'h0B05, 15);
    tick(2);
    CS = 1'b1;
    watch(vc, ec, pc);
    model_apply(32'h0B05, 16);
    check_pulses("cs_fall+sclk", vc, ec, pc, 1'b1, 1'b0);
    check_model_state("cs_fall+sclk");
    $display("seq cs_fall+sclk frame=0B05 wr_valid=%0d frame_err=%0d scan_limit=%0d", vc, ec, scan_limit);
    tick(2);

    // SCLK rise coinciding with CS rise must not shift in an extra bit.
    CS = 1'b0;
    tick(3);
    shift_bits(32'h0A03, 16);
    DIN = 1'b1;
    tick(2);
    CS = 1'b1; SCLK = 1'b1;
    watch(vc, ec, pc);
    SCLK = 1'b0;
    model_apply(32'h0A03, 16);
    check_pulses("cs_rise+sclk", vc, ec, pc, 1'b1, 1'b0);
    check_model_state("cs_rise+sclk");
    $display("seq cs_rise+sclk frame=0A03 wr_valid=%0d intensity=%0h", vc, intensity);
    tick(2);

    // Reset mid-frame: 8 bits, reset with CS held low, then a fresh 16 bits.
    row_sel = 3'd0;
    CS = 1'b0;
    tick(3);
    shift_bits(32'hFF, 8);
    rst_n = 1'b0;
    tick(2);
    model_reset();
    check_model_state("in_reset");
    check("in_reset row_data", row_data, 0);
    rst_n = 1'b1;
    tick(4);
    check_model_state("post_reset");
    check("post_reset row_data", row_data, 0);
    shift_bits(32'h0A05, 16);
    tick(2);
    CS = 1'b1;
    watch(vc, ec, pc);
    model_apply(32'h0A05, 16);
    check_pulses("reset_midframe", vc, ec, pc, 1'b1, 1'b0);
    check_model_state("reset_midframe");
    sweep_rows("reset_midframe");
    $display("seq reset_midframe frame=0A05 wr_valid=%0d frame_err=%0d shutdown=%0d", vc, ec, shutdown);
    tick(2);

    // Randomized frames against the model.
    for (int r = 0; r < 40; r++) begin
      rbits = $urandom;
      sel   = int'($urandom_range(0, 9));
      if (sel == 0)      rn = 0;
      else if (sel == 1) rn = int'($urandom_range(1, 15));
      else if (sel == 2) rn = int'($urandom_range(17, 24));
      else               rn = 16;
      // Bias towards digit rows and the control registers that gate them.
      if (sel >= 7) rbits[11:8] = 4'($urandom_range(1, 8));
      run_frame(rbits, rn, vc, ec, pc);
      check_pulses($sformatf("rnd%0d", r), vc, ec, pc, m_ev, m_ee);
      check_model_state($sformatf("rnd%0d", r));
      sweep_rows($sformatf("rnd%0d", r));
      $display("rnd%0d bits=%0h n=%0d wr_valid=%0d frame_err=%0d", r, rbits, rn, vc, ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
# max7219_rx

Receive-side model of the MAX7219 serial interface: samples DIN/SCLK/CS in the `clk` domain, assembles 16-bit frames, and decodes them into the MAX7219 register file (digit rows 1–8, decode, intensity, scan limit, shutdown, display test). It sits opposite our MAX7219 driver. It serves as an on-chip loopback checker and as a display-state monitor for simulation and FPGA bring-up. Decoded state is exported as control outputs plus an 8×8 frame-buffer read port.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on SCLK, DIN and CS; legal values are 2 or more.

Ports:
- `clk`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `SCLK`, input, 1 bit: serial clock from the driver; asynchronous to `clk`.
- `DIN`, input, 1 bit: serial data, MSB first.
- `CS`, input, 1 bit: load/chip select, active low; a frame is latched on its rising edge.
- `row_sel`, input, 3 bits: frame-buffer row to read; 0 selects digit register 1.
- `row_data`, output, 8 bits: effective row pixels, registered.
- `wr_valid`, output, 1 bit: one-cycle pulse per accepted frame.
- `wr_addr`, output, 4 bits: address nibble (bits [11:8]) of the last accepted frame.
- `wr_data`, output, 8 bits: data byte (bits [7:0]) of the last accepted frame.
- `frame_err`, output, 1 bit: one-cycle pulse when a frame is rejected as short.
- `shutdown`, output, 1 bit: 1 means the display is in shutdown.
- `decode_mode`, output, 8 bits: contents of the decode register.
- `intensity`, output, 4 bits: contents of the intensity register.
- `scan_limit`, output, 3 bits: contents of the scan-limit register.
- `display_test`, output, 1 bit: display-test mode active.

## Operation

- **Input conditioning:** SCLK, DIN and CS each pass through `SYNC_STAGES` flops. A one-flop history register on SCLK and CS gives rise and fall detection.
- **Frame start:** a CS falling edge clears the 5-bit bit counter. The shift register is not cleared.
- **Bit capture:** on each SCLK rising edge while synchronized CS is low:
  - shift `{sr[14:0], DIN_sync}` into the shift register;
  - increment the bit counter, saturating at 16.
- **Frame end:** on a CS rising edge:
  - **count = 16:** accept the frame.
    - Pulse `wr_valid`.
    - Load `wr_addr` with `sr[11:8]` and `wr_data` with `sr[7:0]`.
    - Update the addressed register in that same cycle.
    - Bits `sr[15:12]` are ignored.
    - A frame longer than 16 bits keeps only its last 16 bits; this is MAX7219 behaviour.
  - **count 1–15:** pulse `frame_err`; no register changes.
  - **count 0:** no action; this covers a CS glitch.
- **Register decode:**
  - 0x0 no-op: `wr_valid` still pulses.
  - 0x1–0x8: digit row (addr−1).
  - 0x9: `decode_mode`.
  - 0xA: `intensity` = data[3:0].
  - 0xB: `scan_limit` = data[2:0].
  - 0xC: `shutdown` = ~data[0].
  - 0xF: `display_test` = data[0].
  - 0xD, 0xE: `wr_valid` pulses, no register changes.
- **Effective row**, registered each cycle in priority order:
  1. `display_test` → 0xFF;
  2. `shutdown`, or `row_sel` > `scan_limit` → 0x00;
  3. otherwise the frame-buffer row `row_sel`.
- **Reset values:**
  - `shutdown` = 1; all other outputs 0.
  - Frame-buffer rows = 0x00, bit counter = 0, shift register = 0.
- **Reset mid-frame:** the partial frame is discarded. After release, bits are counted from 0 even if CS is already low. No `frame_err` is produced for the aborted frame.
- **Simultaneous events:** an SCLK rise detected in the same cycle as a CS rise is ignored. A CS fall and an SCLK rise detected in the same cycle: the counter is cleared, then the bit is counted, so count = 1.

## Timing

- Pin edge to detection is `SYNC_STAGES`+1 clk cycles. The same delay applies to SCLK and CS, so event order is preserved when edges are ≥1 clk apart.
- Input constraints:
  - SCLK high and low times ≥ 2 clk periods each.
  - DIN stable from 1 clk before to `SYNC_STAGES` clk after the SCLK rise.
  - CS rise ≥ 2 clk after the last SCLK rise.
- Latency with the default parameter: CS pin rise → `wr_valid`, `frame_err` and register update = 3 clk cycles.
- Latency to `row_data`: 1 clk after a change in `row_sel` or in register state.
- Back-to-back frames are accepted at any CS high time of ≥ 2 clk; there is no busy state.

## Configuration

- `MAX7219_RX_FRAMEBUF_EN`:
  - **Defined:** the 8×8 frame buffer and effective-row logic are present, as described above.
  - **Undefined:** no row storage; `row_data` is constant 0x00 and `row_sel` is unused. The `wr_*` stream, `frame_err` and control registers are unchanged.

## Test plan

- **Init sequence:** frames 0x0C01, 0x0900, 0x0B07, 0x0A0F, 0x0F00 → five `wr_valid` pulses; `shutdown`=0, `decode_mode`=0x00, `scan_limit`=7, `intensity`=0xF, `display_test`=0.
- **Row write:** write 0x013C after init, `row_sel`=0 → `row_data`=0x3C one clk later; `wr_addr`=1, `wr_data`=0x3C.
- **Short frame:** 12 bits then CS high → `frame_err` pulse 3 clk after the CS rise; no `wr_valid`; registers unchanged.
- **Long frame:** 24 bits 0xAB0305 → accepted as 0x0305; row 2 = 0x05.
- **Overrides:**
  - 0x0F01 → `row_data`=0xFF for every `row_sel`.
  - Then 0x0F00, 0x0B02, `row_sel`=5 → 0x00.
  - Then 0x0C00 with `row_sel`=0 → 0x00.
- **Reset mid-frame:** assert `rst_n` after 8 bits, release while CS is still low, send 16 more bits, raise CS → frame accepted from those 16 bits; all registers held reset values until then, with `shutdown`=1.
